// File: rtl/mips_pkg.sv
// Shared fetch-stage constants and the prefetch queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_PC_STEP  = 4;
    localparam int DEF_RESET_PC = 0;

    // One queued fetch: the instruction and the PC of the instruction after it.
    // Stages built at the default widths can use this type directly.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc_next;
    } fq_entry_t;

endpackage : mips_pkg

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: instruction memory port, redirect and decode handshake.
// Latency: n/a (wiring only).
// Backpressure: decode stalls the queue head by holding out_ready low.
interface fetch_queue_if #(
    parameter int ADDR_W = mips_pkg::DEF_ADDR_W,
    parameter int DATA_W = mips_pkg::DEF_DATA_W,
    parameter int DEPTH  = 4
);
    logic                     fetch_en;
    logic [ADDR_W-1:0]        imem_addr;
    logic [DATA_W-1:0]        imem_data;
    logic                     redirect;
    logic [ADDR_W-1:0]        redirect_pc;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_instr;
    logic [ADDR_W-1:0]        out_pc_next;
    logic [$clog2(DEPTH):0]   count;

    // The fetch queue itself.
    modport master (
        input  fetch_en, imem_data, redirect, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc_next, count
    );

    // Memory, branch unit and decode stage surrounding the queue.
    modport slave (
        output fetch_en, imem_data, redirect, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc_next, count
    );
endinterface : fetch_queue_if

// File: rtl/fetch_fifo.sv
// Prefetch storage: DEPTH-entry circular buffer with flush.
// Latency: an entry pushed at edge N is on head in cycle N+1.
// Backpressure: pushes into a full buffer are dropped unless a pop shares the cycle.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wr_dat,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    // A full buffer still takes a write when the head leaves in the same cycle.
    assign w_do_push = push & (~full | (pop & ~empty));
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage write; contents are never reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_dat;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the buffer like reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule : fetch_fifo

// File: rtl/fetch_queue.sv
// Instruction fetch: PC register feeding a combinational imem into a prefetch queue.
// Latency: imem word at PC visible at the head one cycle after its push; redirect target two cycles.
// Backpressure: out_ready low stalls the head; a full queue or fetch_en low freezes the PC.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 4,
    parameter int PC_STEP  = DEF_PC_STEP,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.master bus
);
    // Same layout as fq_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc_next;
    } entry_t;

    logic [ADDR_W-1:0]      r_pc;
    logic [ADDR_W-1:0]      w_pc_next;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    entry_t                 w_wr_entry;
    entry_t                 w_head;

    // Wraps silently modulo 2^ADDR_W.
    assign w_pc_next = r_pc + ADDR_W'(PC_STEP);

    assign w_pop  = ~w_empty & bus.out_ready;
    // Redirect wins: the word at the stale PC must not enter the queue.
    assign w_push = bus.fetch_en & ~bus.redirect & (~w_full | w_pop);

    assign w_wr_entry.instr   = bus.imem_data;
    assign w_wr_entry.pc_next = w_pc_next;

    assign bus.imem_addr   = r_pc;
    assign bus.out_valid   = ~w_empty;
    assign bus.out_instr   = w_head.instr;
    assign bus.out_pc_next = w_head.pc_next;
    assign bus.count       = w_count;

    // PC update: reset over redirect over sequential advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else if (bus.redirect) begin
            r_pc <= bus.redirect_pc;
        end else if (w_push) begin
            r_pc <= w_pc_next;
        end
    end

    // A redirect flushes the queue; the head it would have popped is not consumed.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (w_push),
        .pop    (w_pop & ~bus.redirect),
        .flush  (bus.redirect),
        .wr_dat (w_wr_entry),
        .head   (w_head),
        .count  (w_count),
        .full   (w_full),
        .empty  (w_empty)
    );
endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an address-tagged instruction memory.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised by holding out_ready low until the queue saturates.
module tb_fetch_queue;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .PC_STEP  (4),
        .RESET_PC (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Memory word at address A is 0xC0DE00AA.
    assign bus.imem_data = {24'hC0DE00, bus.imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset           = 1'b1;
        bus.fetch_en    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h want 00", bus.imem_addr); end
    endtask

    task automatic test_stream();
        bus.fetch_en  = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++; if (bus.imem_addr !== 8'(4*k)) begin n_fail++; $display("FAIL stream_addr[%0d] got %h want %h", k, bus.imem_addr, 8'(4*k)); end
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b want 1", k, bus.out_valid); end
            n_checks++; if (bus.out_instr !== (32'hC0DE0000 + 32'(4*(k-1)))) begin n_fail++; $display("FAIL stream_instr[%0d] got %h want %h", k, bus.out_instr, 32'hC0DE0000 + 32'(4*(k-1))); end
            n_checks++; if (bus.out_pc_next !== 8'(4*k)) begin n_fail++; $display("FAIL stream_pcn[%0d] got %h want %h", k, bus.out_pc_next, 8'(4*k)); end
            n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d] got %0d want 1", k, bus.count); end
        end
    endtask

    task automatic test_fill();
        int exp_n;
        apply_reset();
        bus.fetch_en  = 1'b1;
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_n = (k < 4) ? k : 4;
            n_checks++; if (bus.count !== 3'(exp_n)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", k, bus.count, exp_n); end
            n_checks++; if (bus.imem_addr !== 8'(4*exp_n)) begin n_fail++; $display("FAIL fill_addr[%0d] got %h want %h", k, bus.imem_addr, 8'(4*exp_n)); end
            n_checks++; if (bus.out_instr !== 32'hC0DE0000) begin n_fail++; $display("FAIL fill_head[%0d] got %h want C0DE0000", k, bus.out_instr); end
        end
        n_checks++; if (bus.out_pc_next !== 8'h04) begin n_fail++; $display("FAIL fill_pcn got %h want 04", bus.out_pc_next); end
    endtask

    task automatic test_full_push_pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fullpp_count got %0d want 4", bus.count); end
        n_checks++; if (bus.imem_addr !== 8'h14) begin n_fail++; $display("FAIL fullpp_addr got %h want 14", bus.imem_addr); end
        n_checks++; if (bus.out_instr !== 32'hC0DE0004) begin n_fail++; $display("FAIL fullpp_head got %h want C0DE0004", bus.out_instr); end
        n_checks++; if (bus.out_pc_next !== 8'h08) begin n_fail++; $display("FAIL fullpp_pcn got %h want 08", bus.out_pc_next); end
    endtask

    task automatic test_redirect();
        // Drain one entry with fetch stalled: PC must hold.
        bus.fetch_en  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL stall_count got %0d want 3", bus.count); end
        n_checks++; if (bus.imem_addr !== 8'h14) begin n_fail++; $display("FAIL stall_addr got %h want 14", bus.imem_addr); end
        bus.fetch_en    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h40;
        #1;
        n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count got %0d want 3", bus.count); end
        tick();
        bus.redirect = 1'b0;
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL redir_count got %0d want 0", bus.count); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.imem_addr !== 8'h40) begin n_fail++; $display("FAIL redir_addr got %h want 40", bus.imem_addr); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL redir2_valid got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_instr !== 32'hC0DE0040) begin n_fail++; $display("FAIL redir2_instr got %h want C0DE0040", bus.out_instr); end
        n_checks++; if (bus.out_pc_next !== 8'h44) begin n_fail++; $display("FAIL redir2_pcn got %h want 44", bus.out_pc_next); end
        n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL redir2_count got %0d want 1", bus.count); end
    endtask

    task automatic test_wrap();
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFC;
        tick();
        bus.redirect = 1'b0;
        n_checks++; if (bus.imem_addr !== 8'hFC) begin n_fail++; $display("FAIL wrap_pre_addr got %h want FC", bus.imem_addr); end
        tick();
        n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_addr got %h want 00", bus.imem_addr); end
        n_checks++; if (bus.out_instr !== 32'hC0DE00FC) begin n_fail++; $display("FAIL wrap_instr got %h want C0DE00FC", bus.out_instr); end
        n_checks++; if (bus.out_pc_next !== 8'h00) begin n_fail++; $display("FAIL wrap_pcn got %h want 00", bus.out_pc_next); end
        tick();
        n_checks++; if (bus.count !== 3'd2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", bus.count); end
        n_checks++; if (bus.imem_addr !== 8'h04) begin n_fail++; $display("FAIL wrap_addr2 got %h want 04", bus.imem_addr); end
    endtask

    task automatic test_reset_mid();
        reset           = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h80;
        tick();
        reset        = 1'b0;
        bus.redirect = 1'b0;
        bus.fetch_en = 1'b0;
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count got %0d want 0", bus.count); end
        n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL rstmid_addr got %h want 00", bus.imem_addr); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", bus.out_valid); end
        tick();
        n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL rstmid_hold got %h want 00", bus.imem_addr); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stream();
        test_fill();
        test_full_push_pop();
        test_redirect();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_fetch_queue
